exe_wb_arbiter: RTL and testbench
=================================

# exe_wb_arbiter

Sits between the functional-unit array and the writeback/complete stage. It takes up to `ISSUE_WIDTH` execute packets per cycle, one per FU lane, and buffers each lane in a small FIFO. Each cycle it grants up to `WB_WIDTH` buffered packets with rotating priority and drives them to the writeback ports as registered packets. Per-lane ready signals throttle issue so that no lane FIFO overflows, including the fixed-latency multiplier lane.

## Interface

Parameters:
- `ISSUE_WIDTH`, default 7: number of FU lanes (execute packet inputs).
- `WB_WIDTH`, default 3: writeback ports per cycle.
- `FIFO_DEPTH`, default 4: entries per lane FIFO; power of two, ≥ `MULT_LATENCY`+2.
- `MULT_LANE`, default 4: index of the multiplier lane.
- `MULT_LATENCY`, default 2: issue-to-execute-packet delay of the multiplier lane, in cycles.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `pipe_flush`, in, 1: synchronous flush; discards all buffered and arriving packets.
- `execute_pkt[0:ISSUE_WIDTH-1]`, in, EXECUTE_PACKET each: FU results. An entry is present when its `packet_valid` is 1.
- `lane_ready[0:ISSUE_WIDTH-1]`, out, 1 each: issue may send a packet on lane i this cycle.
- `wb_pkt[0:WB_WIDTH-1]`, out, EXECUTE_PACKET each: registered writeback packets; valid when `packet_valid`=1.
- `lane_count[0:ISSUE_WIDTH-1]`, out, $clog2(FIFO_DEPTH)+1 each: current FIFO occupancy, for debug and performance counters.

## Operation

- **Enqueue.** On each clock edge, a lane whose `execute_pkt[i].packet_valid`=1 writes the whole packet at its FIFO tail.
- **Enqueue when full.** This is a protocol violation. An assertion fires, the packet is dropped, and the FIFO state is unchanged.
- **Ready, ordinary lanes.** `lane_ready[i]` = (`lane_count[i]` < `FIFO_DEPTH`). It is computed from registered counts only and ignores dequeues in the same cycle (conservative).
- **Ready, multiplier lane.** `lane_ready[MULT_LANE]` = (`lane_count` ≤ `FIFO_DEPTH`-1-`MULT_LATENCY`). This reserves slots for multiplies already in flight.
- **Arbitration.**
  - Register `rr_ptr` is in the range 0..`ISSUE_WIDTH`-1.
  - Scan lanes `rr_ptr`, `rr_ptr`+1, … modulo `ISSUE_WIDTH`.
  - Grant the first `WB_WIDTH` lanes whose FIFOs are non-empty, at most one entry per lane per cycle.
  - Grant k (in scan order) drives `wb_pkt[k]`.
- **Pointer update.** On the next edge `rr_ptr` becomes (last granted lane + 1) modulo `ISSUE_WIDTH`. It is unchanged if there are no grants.
- **Dequeue.** Granted heads pop on the edge. `wb_pkt[k]` registers the granted packet; ungranted ports register `packet_valid`=0.
- **Same-cycle push and pop.** Enqueue and dequeue on the same lane in the same cycle are allowed. The count is unchanged, and this is legal even when the FIFO is full.
- **No filtering.** Packets with `dest_prn`=0 (stores, conditional branches) are still granted so that the ROB sees completion. Downstream suppresses the PRF write.
- **Ordering.** Packets keep FIFO order within a lane. There is no ordering across lanes.
- **Flush.** When `pipe_flush`=1, on the edge:
  - all FIFO pointers and counts clear;
  - the `packet_valid` of every `wb_pkt` becomes 0;
  - `rr_ptr` becomes 0;
  - that cycle's inputs are dropped.
- **Flush vs. reset.** `rst_n`=0 has priority over `pipe_flush` and has the same effect.

## Timing

- **Reset values:**
  - `lane_count` = 0.
  - `lane_ready` = 1 on every lane, including the multiplier lane.
  - `wb_pkt[*]` = 0, including `packet_valid`.
  - `rr_ptr` = 0.
- **Latency.** Minimum 2 cycles: a packet valid in cycle t enqueues at the end of t, is granted in t+1, and appears on `wb_pkt` in cycle t+2.
- **Throughput.** `WB_WIDTH` packets per cycle in total, at most 1 per lane.
- **Ready timing.** `lane_ready` reflects counts after the previous edge. Issue samples it in the same cycle it sends.
- **Multiplier lane.** With depth 4 and latency 2, ready holds only while count ≤ 1. Worst case is count 1, plus 2 in flight, plus 1 new packet = 4 entries, which does not overflow.
- **Flush.** A flush in cycle t leaves no valid `wb_pkt` in t+1. A packet arriving in t+1 appears on `wb_pkt` no earlier than t+3.
- **Reset mid-operation.** Identical to flush, and all state clears.

## Test plan

1. **Single packet latency.** After reset, a lane-0 packet with `dest_prn`=5 and result 0x1234 arrives in cycle 10. Required: `wb_pkt[0]` is valid in cycle 12 with the same fields; lane counts return to 0.
2. **Oversubscription and fairness.** All 7 lanes send one packet in cycle 0. Required:
   - Cycle 2: lanes 0,1,2 on ports 0,1,2.
   - Cycle 3: lanes 3,4,5.
   - Cycle 4: lane 6 on port 0.
   - `rr_ptr` reads 3, then 6, then 0.
3. **Backpressure.** Lane 1 sends 5 consecutive packets while granted every cycle. Required: `lane_ready[1]` never drops. Then hold grants away from lane 1 by making lanes 2..6 and 0 continuously valid: lane 1 fills to 4, `lane_ready[1]`=0, and no packet is dropped.
4. **Multiplier reservation.** Lane 4 count reaches 2 with 2 multiplies in flight. Required: `lane_ready[4]`=0, and in-flight arrivals make the count reach 4 with no overflow assertion.
5. **Flush.** Three lanes are half-full and `pipe_flush` pulses in cycle 20 while new packets arrive. Required: in cycle 21 all counts are 0, all `wb_pkt` are invalid, and no packet from before or during the flush ever appears.
6. **Reset during traffic.** Drop `rst_n` for one cycle during the scenario 2 traffic. Required: in the next cycle all outputs hold their reset values and `lane_ready` = all ones.

Source files
------------

// File: rtl/exe_wb_arbiter.sv
// Execute-to-writeback arbiter: one FIFO per FU lane, drained by a rotating-priority
// grant of up to WB_WIDTH packets per cycle onto registered writeback ports.
package exe_wb_pkg;
  typedef struct packed {
    logic        packet_valid;
    logic [5:0]  rob_idx;
    logic [6:0]  dest_prn;
    logic [31:0] result;
  } execute_packet_t;
endpackage

module exe_wb_arbiter_chk #(
  parameter int ISSUE_WIDTH = 7,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   pipe_flush,
  input logic [ISSUE_WIDTH-1:0] push_req,
  input logic [ISSUE_WIDTH-1:0] pop,
  input logic [CNT_W-1:0]       count [ISSUE_WIDTH]
);
  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
    // A packet offered to a full FIFO that does not pop on the same edge is lost.
    no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n || pipe_flush)
      !(push_req[i] && !pop[i] && (count[i] == CNT_W'(FIFO_DEPTH))));
  end
endmodule

module exe_wb_arbiter
  import exe_wb_pkg::*;
#(
  parameter int ISSUE_WIDTH  = 7,
  parameter int WB_WIDTH     = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int MULT_LANE    = 4,
  parameter int MULT_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipe_flush,
  input  execute_packet_t               execute_pkt [ISSUE_WIDTH],
  output logic                          lane_ready  [ISSUE_WIDTH],
  output execute_packet_t               wb_pkt      [WB_WIDTH],
  output logic [$clog2(FIFO_DEPTH):0]   lane_count  [ISSUE_WIDTH]
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = $clog2(ISSUE_WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MULT_MAX_C = CNT_W'(FIFO_DEPTH - 1 - MULT_LATENCY);

  execute_packet_t        mem_r   [ISSUE_WIDTH][FIFO_DEPTH];
  logic [PTR_W-1:0]       head_r  [ISSUE_WIDTH];
  logic [PTR_W-1:0]       tail_r  [ISSUE_WIDTH];
  logic [CNT_W-1:0]       count_r [ISSUE_WIDTH];
  logic [LANE_W-1:0]      rr_ptr_r;
  logic [LANE_W-1:0]      rr_next_s;
  logic [ISSUE_WIDTH-1:0] req_s;
  logic [ISSUE_WIDTH-1:0] push_s;
  logic [ISSUE_WIDTH-1:0] grant_s;
  logic [LANE_W-1:0]      sel_s [WB_WIDTH];
  logic [WB_WIDTH-1:0]    sel_vld_s;
  logic                   hit_s;
  int                     scan_s;
  int                     n_grant_s;

  // Ready and occupancy come from registered counts only; the multiplier lane
  // keeps MULT_LATENCY slots spare for operations already in its pipeline.
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      lane_count[i] = count_r[i];
      if (i == MULT_LANE) begin
        lane_ready[i] = (count_r[i] <= MULT_MAX_C);
      end else begin
        lane_ready[i] = (count_r[i] < DEPTH_C);
      end
    end
  end

  // Rotating-priority scan from rr_ptr: the first WB_WIDTH non-empty lanes win, in port order.
  always_comb begin
    grant_s   = '0;
    sel_vld_s = '0;
    rr_next_s = rr_ptr_r;
    n_grant_s = 0;
    scan_s    = 0;
    hit_s     = 1'b0;
    for (int k = 0; k < WB_WIDTH; k++) begin
      sel_s[k] = '0;
    end
    for (int off = 0; off < ISSUE_WIDTH; off++) begin
      scan_s = int'(rr_ptr_r) + off;
      scan_s = (scan_s >= ISSUE_WIDTH) ? (scan_s - ISSUE_WIDTH) : scan_s;
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        hit_s      = (l == scan_s) && (count_r[l] != '0) && (n_grant_s < WB_WIDTH);
        grant_s[l] = grant_s[l] | hit_s;
        for (int k = 0; k < WB_WIDTH; k++) begin
          sel_vld_s[k] = sel_vld_s[k] | (hit_s && (k == n_grant_s));
          sel_s[k]     = (hit_s && (k == n_grant_s)) ? LANE_W'(l) : sel_s[k];
        end
        rr_next_s = hit_s ? ((l == ISSUE_WIDTH - 1) ? '0 : LANE_W'(l + 1)) : rr_next_s;
        n_grant_s = n_grant_s + int'(hit_s);
      end
    end
  end

  // A push is accepted when there is room, or when the same lane pops this edge.
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      req_s[i]  = execute_pkt[i].packet_valid;
      push_s[i] = req_s[i] && ((count_r[i] < DEPTH_C) || grant_s[i]);
    end
  end

  // FIFO storage; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (push_s[i]) begin
        mem_r[i][tail_r[i]] <= execute_pkt[i];
      end
    end
  end

  // Pointers, counts, round-robin pointer and writeback registers; flush acts like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || pipe_flush) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        head_r[i]  <= '0;
        tail_r[i]  <= '0;
        count_r[i] <= '0;
      end
      for (int k = 0; k < WB_WIDTH; k++) begin
        wb_pkt[k] <= '0;
      end
      rr_ptr_r <= '0;
    end else begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (push_s[i]) begin
          tail_r[i] <= tail_r[i] + PTR_W'(1);
        end
        if (grant_s[i]) begin
          head_r[i] <= head_r[i] + PTR_W'(1);
        end
        count_r[i] <= count_r[i] + CNT_W'(push_s[i]) - CNT_W'(grant_s[i]);
      end
      for (int k = 0; k < WB_WIDTH; k++) begin
        wb_pkt[k] <= sel_vld_s[k] ? mem_r[sel_s[k]][head_r[sel_s[k]]] : '0;
      end
      rr_ptr_r <= rr_next_s;
    end
  end

  exe_wb_arbiter_chk #(
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CNT_W       (CNT_W)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_flush (pipe_flush),
    .push_req   (req_s),
    .pop        (grant_s),
    .count      (count_r)
  );
endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Self-checking bench for exe_wb_arbiter: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the arbiter.
module tb_exe_wb_arbiter;
  import exe_wb_pkg::*;

  localparam int IW    = 7;
  localparam int WB    = 3;
  localparam int DEPTH = 4;
  localparam int MULT  = 4;
  localparam int LAT   = 2;
  localparam int CW    = 3;
  localparam int LW    = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pipe_flush;
  execute_packet_t execute_pkt [IW];
  logic            lane_ready  [IW];
  execute_packet_t wb_pkt      [WB];
  logic [CW-1:0]   lane_count  [IW];

  exe_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_flush  (pipe_flush),
    .execute_pkt (execute_pkt),
    .lane_ready  (lane_ready),
    .wb_pkt      (wb_pkt),
    .lane_count  (lane_count)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per lane, a rotating start lane, and the expected ports.
  execute_packet_t q [IW][$];
  int              m_rr;
  execute_packet_t m_wb [WB];
  int              m_drops;
  execute_packet_t mpipe [LAT];
  int              n_checks;
  int              n_fail;
  int              cyc;
  int              seq;

  function automatic execute_packet_t mk(input int lane, input logic [3:0] epoch);
    execute_packet_t p;
    p.packet_valid = 1'b1;
    p.rob_idx      = 6'($urandom_range(0, 63));
    p.dest_prn     = 7'($urandom_range(0, 127));
    p.result       = {epoch, lane[3:0], seq[23:0]};
    seq++;
    return p;
  endfunction

  function automatic logic exp_ready(input int i);
    if (i == MULT) return (q[i].size() <= DEPTH - 1 - LAT);
    return (q[i].size() < DEPTH);
  endfunction

  task automatic model_edge();
    int n;
    int last;
    if (!rst_n || pipe_flush) begin
      for (int i = 0; i < IW; i++) q[i].delete();
      for (int k = 0; k < WB; k++) m_wb[k] = '0;
      m_rr = 0;
    end else begin
      n = 0;
      last = -1;
      for (int k = 0; k < WB; k++) m_wb[k] = '0;
      for (int off = 0; off < IW; off++) begin
        int l;
        l = (m_rr + off) % IW;
        if (q[l].size() > 0 && n < WB) begin
          m_wb[n] = q[l].pop_front();
          n++;
          last = l;
        end
      end
      if (last >= 0) m_rr = (last + 1) % IW;
      for (int i = 0; i < IW; i++) begin
        if (execute_pkt[i].packet_valid) begin
          if (q[i].size() < DEPTH) q[i].push_back(execute_pkt[i]);
          else m_drops++;
        end
      end
    end
  endtask

  // Advance one clock: update the model, take the edge, then return inputs to idle.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n || pipe_flush) begin
      for (int j = 0; j < LAT; j++) mpipe[j] = '0;
    end
    for (int i = 0; i < IW; i++) execute_pkt[i] = '0;
    pipe_flush = 1'b0;
    rst_n      = 1'b1;
  endtask

  // Issue on every masked lane that is ready; the multiplier lane arrives LAT cycles after issue.
  task automatic drive_traffic(input logic [IW-1:0] mask, input logic [3:0] epoch);
    for (int i = 0; i < IW; i++) begin
      if (i != MULT && mask[i] && lane_ready[i]) execute_pkt[i] = mk(i, epoch);
    end
    execute_pkt[MULT] = mpipe[LAT-1];
    for (int j = LAT - 1; j > 0; j--) mpipe[j] = mpipe[j-1];
    mpipe[0] = (mask[MULT] && lane_ready[MULT]) ? mk(MULT, epoch) : '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < IW; i++) begin
      n_checks++;
      if (lane_count[i] !== 3'd0 || lane_ready[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_lane[%0d]: count/ready got %0d/%0b, expected 0/1", i, lane_count[i], lane_ready[i]);
      end
    end
    for (int k = 0; k < WB; k++) begin
      n_checks++;
      if (wb_pkt[k] !== '0) begin
        n_fail++;
        $display("FAIL reset_wb[%0d]: got %h, expected 0", k, wb_pkt[k]);
      end
    end
    n_checks++;
    if (dut.rr_ptr_r !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_rr: got %0d, expected 0", dut.rr_ptr_r);
    end
  endtask

  task automatic test_single_latency();
    execute_packet_t p;
    repeat (8) tick();
    p = '{packet_valid: 1'b1, rob_idx: 6'd3, dest_prn: 7'd5, result: 32'h1234};
    execute_pkt[0] = p;
    tick();
    n_checks++;
    if (lane_count[0] !== 3'd1 || wb_pkt[0].packet_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_t1: count/valid got %0d/%0b, expected 1/0", lane_count[0], wb_pkt[0].packet_valid);
    end
    tick();
    n_checks++;
    if (wb_pkt[0] !== p || lane_count[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL lat_t2: got %h count %0d, expected %h count 0", wb_pkt[0], lane_count[0], p);
    end
    for (int k = 1; k < WB; k++) begin
      n_checks++;
      if (wb_pkt[k].packet_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL lat_port[%0d]: valid got %0b, expected 0", k, wb_pkt[k].packet_valid);
      end
    end
    tick();
    n_checks++;
    if (wb_pkt[0].packet_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_t3: valid got %0b, expected 0", wb_pkt[0].packet_valid);
    end
  endtask

  task automatic test_fairness();
    execute_packet_t sent [IW];
    int exp_lane [3][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, -1, -1}};
    int exp_rr [3] = '{3, 6, 0};
    pipe_flush = 1'b1;
    tick();
    for (int i = 0; i < IW; i++) begin
      sent[i] = mk(i, 4'h1);
      execute_pkt[i] = sent[i];
    end
    tick();
    tick();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < WB; k++) begin
        n_checks++;
        if (exp_lane[c][k] >= 0) begin
          if (wb_pkt[k] !== sent[exp_lane[c][k]]) begin
            n_fail++;
            $display("FAIL fair_c%0d_port%0d: got %h, expected %h", c + 2, k, wb_pkt[k], sent[exp_lane[c][k]]);
          end
        end else if (wb_pkt[k].packet_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL fair_c%0d_port%0d: valid got 1, expected 0", c + 2, k);
        end
      end
      n_checks++;
      if (dut.rr_ptr_r !== LW'(exp_rr[c])) begin
        n_fail++;
        $display("FAIL fair_rr_c%0d: got %0d, expected %0d", c + 2, dut.rr_ptr_r, exp_rr[c]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit saw_full = 1'b0;
    pipe_flush = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (lane_ready[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_ready_c%0d: got %0b, expected 1", c, lane_ready[1]);
      end
      if (lane_ready[1]) execute_pkt[1] = mk(1, 4'h2);
      tick();
    end
    repeat (2) tick();
    for (int c = 0; c < 24; c++) begin
      drive_traffic('1, 4'h2);
      tick();
      for (int k = 0; k < WB; k++) begin
        n_checks++;
        if (wb_pkt[k] !== m_wb[k]) begin
          n_fail++;
          $display("FAIL bp_wb[%0d] cycle %0d: got %h, expected %h", k, cyc, wb_pkt[k], m_wb[k]);
        end
      end
      for (int i = 0; i < IW; i++) begin
        n_checks++;
        if (lane_count[i] !== CW'(q[i].size()) || lane_ready[i] !== exp_ready(i)) begin
          n_fail++;
          $display("FAIL bp_lane[%0d] cycle %0d: count/ready got %0d/%0b, expected %0d/%0b",
                   i, cyc, lane_count[i], lane_ready[i], q[i].size(), exp_ready(i));
        end
      end
      if (lane_count[1] == 3'd4 && lane_ready[1] == 1'b0) saw_full = 1'b1;
    end
    n_checks++;
    if (saw_full !== 1'b1 || m_drops != 0) begin
      n_fail++;
      $display("FAIL bp_fill: saw full/not-ready %0b drops %0d, expected 1 and 0", saw_full, m_drops);
    end
  endtask

  task automatic test_mult_reservation();
    bit saw_hold = 1'b0;
    int max_cnt = 0;
    pipe_flush = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      drive_traffic('1, 4'h3);
      tick();
      n_checks++;
      if (lane_count[MULT] !== CW'(q[MULT].size()) || lane_ready[MULT] !== exp_ready(MULT)) begin
        n_fail++;
        $display("FAIL mult_lane cycle %0d: count/ready got %0d/%0b, expected %0d/%0b",
                 cyc, lane_count[MULT], lane_ready[MULT], q[MULT].size(), exp_ready(MULT));
      end
      for (int k = 0; k < WB; k++) begin
        n_checks++;
        if (wb_pkt[k] !== m_wb[k]) begin
          n_fail++;
          $display("FAIL mult_wb[%0d] cycle %0d: got %h, expected %h", k, cyc, wb_pkt[k], m_wb[k]);
        end
      end
      if (lane_count[MULT] >= 3'd2 && lane_ready[MULT] == 1'b0) saw_hold = 1'b1;
      if (int'(lane_count[MULT]) > max_cnt) max_cnt = int'(lane_count[MULT]);
    end
    n_checks++;
    if (saw_hold !== 1'b1 || m_drops != 0 || max_cnt > DEPTH) begin
      n_fail++;
      $display("FAIL mult_hold: hold %0b drops %0d max %0d, expected 1, 0, <=4", saw_hold, m_drops, max_cnt);
    end
  endtask

  task automatic test_flush();
    pipe_flush = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      drive_traffic('1, 4'hA);
      tick();
    end
    drive_traffic('1, 4'hA);
    pipe_flush = 1'b1;
    tick();
    for (int i = 0; i < IW; i++) begin
      n_checks++;
      if (lane_count[i] !== 3'd0) begin
        n_fail++;
        $display("FAIL flush_count[%0d]: got %0d, expected 0", i, lane_count[i]);
      end
    end
    for (int k = 0; k < WB; k++) begin
      n_checks++;
      if (wb_pkt[k].packet_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_wb[%0d]: valid got 1, expected 0", k);
      end
    end
    execute_pkt[0] = mk(0, 4'hB);
    tick();
    n_checks++;
    if (wb_pkt[0].packet_valid !== 1'b0 || lane_count[0] !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_early: valid/count got %0b/%0d, expected 0/1", wb_pkt[0].packet_valid, lane_count[0]);
    end
    for (int c = 0; c < 7; c++) begin
      tick();
      for (int k = 0; k < WB; k++) begin
        n_checks++;
        if (wb_pkt[k] !== m_wb[k] || (wb_pkt[k].packet_valid && wb_pkt[k].result[31:28] != 4'hB)) begin
          n_fail++;
          $display("FAIL flush_leak[%0d] cycle %0d: got %h, expected %h", k, cyc, wb_pkt[k], m_wb[k]);
        end
      end
    end
  endtask

  task automatic test_reset_traffic();
    pipe_flush = 1'b1;
    tick();
    for (int i = 0; i < IW; i++) execute_pkt[i] = mk(i, 4'hC);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < IW; i++) begin
        n_checks++;
        if (lane_count[i] !== 3'd0 || lane_ready[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL rst_lane[%0d] c%0d: count/ready got %0d/%0b, expected 0/1", i, c, lane_count[i], lane_ready[i]);
        end
      end
      for (int k = 0; k < WB; k++) begin
        n_checks++;
        if (wb_pkt[k] !== '0) begin
          n_fail++;
          $display("FAIL rst_wb[%0d] c%0d: got %h, expected 0", k, c, wb_pkt[k]);
        end
      end
      n_checks++;
      if (dut.rr_ptr_r !== 3'd0) begin
        n_fail++;
        $display("FAIL rst_rr c%0d: got %0d, expected 0", c, dut.rr_ptr_r);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive_traffic(IW'($urandom), 4'($urandom));
      if ($urandom_range(0, 39) == 0) pipe_flush = 1'b1;
      if ($urandom_range(0, 96) == 0) rst_n = 1'b0;
      tick();
      for (int k = 0; k < WB; k++) begin
        n_checks++;
        if (wb_pkt[k] !== m_wb[k]) begin
          n_fail++;
          $display("FAIL rand_wb[%0d] cycle %0d: got %h, expected %h", k, cyc, wb_pkt[k], m_wb[k]);
        end
      end
      for (int i = 0; i < IW; i++) begin
        n_checks++;
        if (lane_count[i] !== CW'(q[i].size()) || lane_ready[i] !== exp_ready(i)) begin
          n_fail++;
          $display("FAIL rand_lane[%0d] cycle %0d: count/ready got %0d/%0b, expected %0d/%0b",
                   i, cyc, lane_count[i], lane_ready[i], q[i].size(), exp_ready(i));
        end
      end
      n_checks++;
      if (dut.rr_ptr_r !== LW'(m_rr)) begin
        n_fail++;
        $display("FAIL rand_rr cycle %0d: got %0d, expected %0d", cyc, dut.rr_ptr_r, m_rr);
      end
    end
    n_checks++;
    if (m_drops != 0) begin
      n_fail++;
      $display("FAIL rand_drops: got %0d, expected 0", m_drops);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    seq        = 0;
    m_rr       = 0;
    m_drops    = 0;
    rst_n      = 1'b0;
    pipe_flush = 1'b0;
    for (int i = 0; i < IW; i++) execute_pkt[i] = '0;
    for (int j = 0; j < LAT; j++) mpipe[j] = '0;
    for (int k = 0; k < WB; k++) m_wb[k] = '0;
    test_reset();
    test_single_latency();
    test_fairness();
    test_backpressure();
    test_mult_reservation();
    test_flush();
    test_reset_traffic();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
